// File: rtl/core1_arbiter_pkg.sv
// Shared definitions for the Core1 operation arbiter: opcodes, FSM encoding
// and the default core settle latency.
package core1_arbiter_pkg;

    localparam int CORE_LAT_DEFAULT = 1;

    // Bits of core_d the core actually defines for a MASK operation.
    localparam int MASK_KEEP = 64;

    localparam logic [2:0] OP_IDLE = 3'd0;
    localparam logic [2:0] OP_SQR  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_LUT  = 3'd3;
    localparam logic [2:0] OP_MASK = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_SQR) || (op == OP_XOR) || (op == OP_LUT) || (op == OP_MASK);
    endfunction

endpackage

// File: rtl/core1_arbiter_rr_arb2.sv
// Two-way round-robin grant. The priority register names the requester that
// wins a tie; it flips away from whoever was just granted.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic r_prio;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio <= 1'b0;
        end else if (o_grant != 2'b00) begin
            r_prio <= o_grant[0];
        end
    end

endmodule

// File: rtl/core1_arbiter.sv
// Shares the Core1 GF(2^m) operation core between two requesters: one op at a
// time, registered operands, fixed settle time, tagged registered result.
module core1_arbiter
    import core1_arbiter_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEFAULT,
    parameter int W        = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2:0]     req_op0,
    input  logic [2:0]     req_op1,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
    output logic [2:0]     core_sel,
    output logic [W-1:0]   core_a,
    output logic [W-1:0]   core_b,
    input  logic [W/2-1:0] core_c,
    input  logic [W/2-1:0] core_d,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic           rsp_err,
    output logic [W/2-1:0] rsp_c,
    output logic [W/2-1:0] rsp_d
);

    localparam int HW = W / 2;
    localparam int CW = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_id;

    logic [1:0]      w_grant;
    logic            w_arb_en;
    logic            w_accept;
    logic            w_sel_id;
    logic [2:0]      w_sel_op;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [HW-1:0]   w_res_c;
    logic [HW-1:0]   w_res_d;

    // Arbitration is only open in IDLE; a reset cycle never accepts.
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (w_arb_en),
        .i_req   (req_valid),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_accept  = (w_grant & req_valid) != 2'b00;
    assign w_sel_id  = w_grant[1];
    assign w_sel_op  = w_sel_id ? req_op1 : req_op0;
    assign w_sel_a   = w_sel_id ? req_a1  : req_a0;
    assign w_sel_b   = w_sel_id ? req_b1  : req_b0;

    // core_sel still holds the op during the last BUSY cycle, so it decides
    // the shaping. MASK only defines the low 64 bits of core_d.
    always_comb begin
        w_res_c = core_c;
        w_res_d = core_d;
        if (core_sel == OP_MASK) begin
            w_res_c = '0;
            w_res_d = {{(HW-MASK_KEEP){1'b0}}, core_d[MASK_KEEP-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_id      <= 1'b0;
            core_sel  <= OP_IDLE;
            core_a    <= '0;
            core_b    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_c     <= '0;
            rsp_d     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id <= w_sel_id;
                        if (op_is_legal(w_sel_op)) begin
                            core_sel <= w_sel_op;
                            core_a   <= w_sel_a;
                            core_b   <= w_sel_b;
                            r_cnt    <= CW'(CORE_LAT);
                            r_state  <= ST_BUSY;
                        end else begin
                            // Illegal ops skip the core entirely.
                            rsp_valid <= 1'b1;
                            rsp_id    <= w_sel_id;
                            rsp_err   <= 1'b1;
                            rsp_c     <= '0;
                            rsp_d     <= '0;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_err   <= 1'b0;
                        rsp_c     <= w_res_c;
                        rsp_d     <= w_res_d;
                        core_sel  <= OP_IDLE;
                        core_a    <= '0;
                        core_b    <= '0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core1_arbiter.sv
// Bench for core1_arbiter: cycle model with table vectors, directed corners,
// random traffic, and a reset-during-BUSY sequence on a CORE_LAT=4 instance.
module tb_core1_arbiter;
    import core1_arbiter_pkg::*;

    localparam int W    = 256;
    localparam int HW   = 128;
    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [2:0]      req_op0 = 3'd0, req_op1 = 3'd0;
    logic [W-1:0]    req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic            rsp_ready = 1'b0;

    logic [1:0]      req_ready1, req_ready4;
    logic [2:0]      core_sel1, core_sel4;
    logic [W-1:0]    core_a1, core_b1, core_a4, core_b4;
    logic [HW-1:0]   core_c1, core_d1, core_c4, core_d4;
    logic            rsp_valid1, rsp_id1, rsp_err1, rsp_valid4, rsp_id4, rsp_err4;
    logic [HW-1:0]   rsp_c1, rsp_d1, rsp_c4, rsp_d4;

    // Core stub: XOR of the operand halves, independent of the select line.
    assign core_c1 = core_a1[W-1:HW] ^ core_b1[W-1:HW];
    assign core_d1 = core_a1[HW-1:0] ^ core_b1[HW-1:0];
    assign core_c4 = core_a4[W-1:HW] ^ core_b4[W-1:HW];
    assign core_d4 = core_a4[HW-1:0] ^ core_b4[HW-1:0];

    core1_arbiter #(.CORE_LAT(LAT), .W(W)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .core_sel(core_sel1), .core_a(core_a1),
        .core_b(core_b1), .core_c(core_c1), .core_d(core_d1), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id1), .rsp_err(rsp_err1), .rsp_c(rsp_c1),
        .rsp_d(rsp_d1)
    );

    core1_arbiter #(.CORE_LAT(LAT4), .W(W)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .core_sel(core_sel4), .core_a(core_a4),
        .core_b(core_b4), .core_c(core_c4), .core_d(core_d4), .rsp_valid(rsp_valid4),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_err(rsp_err4), .rsp_c(rsp_c4),
        .rsp_d(rsp_d4)
    );

    typedef struct {
        logic          id;
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          err;
        logic [HW-1:0] c;
        logic [HW-1:0] d;
        int            lat;
    } vec_t;

    vec_t tbl[9];

    int checks = 0;
    int errors = 0;

    // Operands staged by the test, copied onto the ports at the falling edge.
    logic [2:0]   opIn[2];
    logic [W-1:0] aIn[2];
    logic [W-1:0] bIn[2];

    // Reference model: one outstanding op, its due cycle and expected result.
    bit            modelOn = 1'b1;
    bit            mValid = 1'b0;
    bit            mBusy = 1'b0;
    int            mDue = 0;
    int            cyc = 0;
    logic          mPrio = 1'b0;
    logic          mId = 1'b0;
    logic [2:0]    mOp = 3'd0;
    logic [W-1:0]  mA = '0, mB = '0;
    logic          mErr = 1'b0;
    logic [HW-1:0] mC = '0, mD = '0;
    logic [1:0]    mExpReady = 2'b00;
    logic          mExpRsp = 1'b0;
    bit            accepted = 1'b0;

    logic [1:0]    obsReady;
    logic          obsRspValid, obsId, obsErr;
    logic [HW-1:0] obsC, obsD;

    int grantId[$];
    int grantCyc[$];

    function automatic logic [W-1:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Expected response from the operation rules and the XOR core stub.
    function automatic void refRsp(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic err,
                                   output logic [HW-1:0] c, output logic [HW-1:0] d);
        logic [W-1:0] x;
        x   = a ^ b;
        err = 1'b0;
        c   = x[W-1:HW];
        d   = x[HW-1:0];
        if (op == OP_MASK) begin
            c = '0;
            d = {64'h0, x[63:0]};
        end else if (!(op == OP_SQR || op == OP_XOR || op == OP_LUT)) begin
            err = 1'b1;
            c   = '0;
            d   = '0;
        end
    endfunction

    task automatic compareValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic rdy, input logic r);
        @(negedge clk);
        req_valid = v;
        rsp_ready = rdy;
        rst       = r;
        req_op0   = opIn[0];
        req_op1   = opIn[1];
        req_a0    = aIn[0];
        req_a1    = aIn[1];
        req_b0    = bIn[0];
        req_b1    = bIn[1];
    endtask

    task automatic checkOutput();
        logic [1:0] g;
        logic       inCore;
        obsReady    = req_ready1;
        obsRspValid = rsp_valid1;
        obsId       = rsp_id1;
        obsErr      = rsp_err1;
        obsC        = rsp_c1;
        obsD        = rsp_d1;
        if (modelOn && mValid) begin
            g = 2'b00;
            if (!mBusy && !rst) begin
                if (req_valid == 2'b11) g = mPrio ? 2'b10 : 2'b01;
                else g = req_valid;
            end
            mExpReady = g;
            mExpRsp   = mBusy && (cyc >= mDue);
            inCore    = mBusy && !mErr && (cyc < mDue);
            compareValue("req_ready", req_ready1, g);
            compareValue("rsp_valid", rsp_valid1, mExpRsp);
            compareValue("core_sel", core_sel1, inCore ? mOp : 3'd0);
            compareValue("core_a", core_a1, inCore ? mA : '0);
            compareValue("core_b", core_b1, inCore ? mB : '0);
            if (mExpRsp) begin
                compareValue("rsp_id", rsp_id1, mId);
                compareValue("rsp_err", rsp_err1, mErr);
                compareValue("rsp_c", rsp_c1, mC);
                compareValue("rsp_d", rsp_d1, mD);
            end
        end
    endtask

    task automatic updateModel();
        accepted = 1'b0;
        if (modelOn) begin
            if (rst) begin
                mValid = 1'b1;
                mBusy  = 1'b0;
                mPrio  = 1'b0;
            end else if (mValid) begin
                if (mExpReady != 2'b00) begin
                    mId = mExpReady[1];
                    mOp = mId ? req_op1 : req_op0;
                    mA  = mId ? req_a1 : req_a0;
                    mB  = mId ? req_b1 : req_b0;
                    refRsp(mOp, mA, mB, mErr, mC, mD);
                    mDue     = cyc + (mErr ? 1 : LAT + 1);
                    mBusy    = 1'b1;
                    mPrio    = !mId;
                    accepted = 1'b1;
                end else if (mExpRsp && rsp_ready) begin
                    mBusy = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic stepCycle(input logic [1:0] v, input logic rdy, input logic r);
        applyStimulus(v, rdy, r);
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
    endtask

    // Stops a hung run with a visible failure rather than spinning forever.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int lat;
        bit got;
        logic [HW-1:0] holdC, holdD;
        logic holdId, holdErr;

        for (int i = 0; i < 2; i++) begin
            opIn[i] = OP_IDLE;
            aIn[i]  = '0;
            bIn[i]  = '0;
        end

        tbl[0] = '{id:1'b0, op:OP_XOR, a:256'hF0, b:256'h0F, err:1'b0, c:128'h0, d:128'hFF, lat:2};
        tbl[1] = '{id:1'b1, op:OP_SQR, a:{128'h1 << 72, 128'h5}, b:256'h3, err:1'b0,
                   c:128'h1 << 72, d:128'h6, lat:2};
        tbl[2] = '{id:1'b1, op:OP_MASK, a:'1, b:'1, err:1'b0, c:128'h0, d:128'h0, lat:2};
        tbl[3] = '{id:1'b1, op:OP_MASK, a:'1, b:'0, err:1'b0, c:128'h0,
                   d:{64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, lat:2};
        tbl[4] = '{id:1'b0, op:3'd6, a:'1, b:'1, err:1'b1, c:128'h0, d:128'h0, lat:1};
        tbl[5] = '{id:1'b1, op:3'd0, a:256'h5, b:256'h9, err:1'b1, c:128'h0, d:128'h0, lat:1};
        tbl[6] = '{id:1'b0, op:OP_LUT, a:{128'hDEAD_BEEF, 128'h0}, b:{128'h0000_FFFF, 128'hCAFE},
                   err:1'b0, c:128'hDEAD_4110, d:128'hCAFE, lat:2};
        tbl[7] = '{id:1'b1, op:3'd7, a:'1, b:256'h1, err:1'b1, c:128'h0, d:128'h0, lat:1};
        tbl[8] = '{id:1'b0, op:OP_MASK, a:{128'hFF, 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_0F0F_0F0F},
                   b:'0, err:1'b0, c:128'h0, d:{64'h0, 64'h0F0F_0F0F_0F0F_0F0F}, lat:2};

        // Reset, then confirm every output sits at its reset value.
        stepCycle(2'b00, 1'b0, 1'b1);
        stepCycle(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        #1;
        compareValue("reset_req_ready", req_ready1, 2'b00);
        compareValue("reset_core_sel", core_sel1, 3'd0);
        compareValue("reset_core_a", core_a1, '0);
        compareValue("reset_core_b", core_b1, '0);
        compareValue("reset_rsp_valid", rsp_valid1, 1'b0);
        compareValue("reset_rsp_id", rsp_id1, 1'b0);
        compareValue("reset_rsp_err", rsp_err1, 1'b0);
        compareValue("reset_rsp_c", rsp_c1, '0);
        compareValue("reset_rsp_d", rsp_d1, '0);
        checkOutput();
        @(posedge clk);
        updateModel();

        // Table vectors: one request at a time, latency and result from the table.
        for (int i = 0; i < 9; i++) begin
            opIn[tbl[i].id]  = tbl[i].op;
            aIn[tbl[i].id]   = tbl[i].a;
            bIn[tbl[i].id]   = tbl[i].b;
            opIn[!tbl[i].id] = 3'($urandom_range(0, 7));
            aIn[!tbl[i].id]  = rand256();
            bIn[!tbl[i].id]  = rand256();
            n = 0;
            accepted = 1'b0;
            while (!accepted && n < 10) begin
                stepCycle(tbl[i].id ? 2'b10 : 2'b01, 1'b1, 1'b0);
                n++;
            end
            compareValue($sformatf("tbl%0d_accept", i), accepted, 1'b1);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                stepCycle(2'b00, 1'b1, 1'b0);
                lat++;
                got = obsRspValid;
            end
            compareValue($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            compareValue($sformatf("tbl%0d_rsp_id", i), obsId, tbl[i].id);
            compareValue($sformatf("tbl%0d_rsp_err", i), obsErr, tbl[i].err);
            compareValue($sformatf("tbl%0d_rsp_c", i), obsC, tbl[i].c);
            compareValue($sformatf("tbl%0d_rsp_d", i), obsD, tbl[i].d);
        end

        // Both requesters hammering SQR: strict alternation, one grant every 3 cycles.
        for (int i = 0; i < 2; i++) begin
            opIn[i] = OP_SQR;
            aIn[i]  = rand256();
            bIn[i]  = rand256();
        end
        for (int k = 0; k < 12; k++) begin
            stepCycle(2'b11, 1'b1, 1'b0);
            if (obsReady != 2'b00) begin
                grantId.push_back(int'(obsReady[1]));
                grantCyc.push_back(k);
            end
        end
        compareValue("fair_grant_count", grantId.size(), 4);
        for (int k = 1; k < grantId.size(); k++) begin
            compareValue($sformatf("fair_alternate%0d", k), grantId[k], 1 - grantId[k-1]);
            compareValue($sformatf("fair_spacing%0d", k), grantCyc[k] - grantCyc[k-1], LAT + 2);
        end

        // Backpressure: response held for 5 cycles, no accept until after handshake.
        opIn[0] = OP_XOR;
        aIn[0]  = rand256();
        bIn[0]  = rand256();
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 10) begin
            stepCycle(2'b01, 1'b1, 1'b0);
            n++;
        end
        compareValue("bp_accept", accepted, 1'b1);
        stepCycle(2'b00, 1'b0, 1'b0);
        holdId  = 1'b0;
        holdErr = 1'b0;
        holdC   = '0;
        holdD   = '0;
        for (int k = 0; k < 5; k++) begin
            stepCycle(2'b11, 1'b0, 1'b0);
            if (k == 0) begin
                holdId  = obsId;
                holdErr = obsErr;
                holdC   = obsC;
                holdD   = obsD;
            end
            compareValue($sformatf("bp_ready_low%0d", k), obsReady, 2'b00);
            compareValue($sformatf("bp_valid%0d", k), obsRspValid, 1'b1);
            compareValue($sformatf("bp_hold_c%0d", k), obsC, holdC);
            compareValue($sformatf("bp_hold_d%0d", k), obsD, holdD);
            compareValue($sformatf("bp_hold_id%0d", k), {obsId, obsErr}, {holdId, holdErr});
        end
        stepCycle(2'b11, 1'b1, 1'b0);
        compareValue("bp_handshake_ready", obsReady, 2'b00);
        stepCycle(2'b11, 1'b1, 1'b0);
        compareValue("bp_after_ready", obsReady != 2'b00, 1'b1);

        // Random traffic against the model, including occasional resets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                opIn[i] = 3'($urandom_range(0, 7));
                aIn[i]  = rand256();
                bIn[i]  = rand256();
            end
            stepCycle(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 99) == 0);
        end

        // Reset during BUSY on the CORE_LAT=4 instance.
        modelOn = 1'b0;
        opIn[0] = OP_XOR;
        aIn[0]  = 256'h1234;
        bIn[0]  = 256'h1;
        opIn[1] = OP_XOR;
        aIn[1]  = 256'h5555;
        bIn[1]  = 256'h1;
        applyStimulus(2'b00, 1'b1, 1'b1);
        @(posedge clk);
        applyStimulus(2'b01, 1'b1, 1'b0);
        #1;
        compareValue("d4_first_ready", req_ready4, 2'b01);
        @(posedge clk);
        applyStimulus(2'b00, 1'b1, 1'b0);
        #1;
        compareValue("d4_busy_sel", core_sel4, OP_XOR);
        @(posedge clk);
        applyStimulus(2'b00, 1'b1, 1'b1);
        #1;
        compareValue("d4_busy_sel_rst", core_sel4, OP_XOR);
        @(posedge clk);
        applyStimulus(2'b11, 1'b1, 1'b0);
        #1;
        compareValue("d4_after_rst_ready", req_ready4, 2'b01);
        compareValue("d4_after_rst_sel", core_sel4, 3'd0);
        compareValue("d4_after_rst_a", core_a4, '0);
        compareValue("d4_after_rst_b", core_b4, '0);
        compareValue("d4_after_rst_valid", rsp_valid4, 1'b0);
        compareValue("d4_after_rst_rsp", {rsp_id4, rsp_err4, rsp_c4, rsp_d4}, '0);
        @(posedge clk);
        got = 1'b0;
        lat = 0;
        holdId = 1'b1;
        holdD  = '0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(2'b00, 1'b1, 1'b0);
            #1;
            if (k <= LAT4) compareValue($sformatf("d4_sel_stable%0d", k), core_sel4, OP_XOR);
            if (rsp_valid4 && !got) begin
                got    = 1'b1;
                lat    = k;
                holdId = rsp_id4;
                holdD  = rsp_d4;
            end
            @(posedge clk);
        end
        compareValue("d4_latency", lat, LAT4 + 1);
        compareValue("d4_rsp_id", holdId, 1'b0);
        compareValue("d4_rsp_d", holdD, 128'h1235);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
